// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encoding, port ids and abort data for the RAM arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } arb_state_e;

    localparam logic        PORT_CPU   = 1'b0;
    localparam logic        PORT_VID   = 1'b1;
    localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-way picker, urgent video first, otherwise round robin against the last grant
module rr_pick2
    import ram_arbiter_pkg::*;
(
    input  logic cpu_req_i,
    input  logic vid_req_i,
    input  logic vid_urgent_i,
    input  logic last_i,
    output logic valid_o,
    output logic pick_o
);

    assign valid_o = cpu_req_i | vid_req_i;
    assign pick_o  = (vid_req_i && (vid_urgent_i || !cpu_req_i || last_i == PORT_CPU)) ? PORT_VID : PORT_CPU;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM controller between a CPU and a video port, one transaction at a time
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [29:0] cpu_address,
    input  logic [31:0] cpu_wr_data,
    input  logic [3:0]  cpu_wr_mask,
    output logic [31:0] cpu_rd_data,
    output logic        cpu_done,
    output logic        cpu_err,
    input  logic        vid_req,
    input  logic        vid_wr,
    input  logic [29:0] vid_address,
    input  logic [31:0] vid_wr_data,
    input  logic [3:0]  vid_wr_mask,
    output logic [31:0] vid_rd_data,
    output logic        vid_done,
    output logic        vid_err,
    input  logic        vid_urgent,
    output logic [29:0] ram_address,
    output logic        ram_wr_enable,
    output logic        ram_rd_enable,
    output logic [31:0] ram_wr_data,
    output logic [3:0]  ram_wr_mask,
    input  logic        ram_wr_ack,
    input  logic        ram_rd_valid,
    input  logic [31:0] ram_rd_data,
    output logic [1:0]  arb_state
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    arb_state_e  state_q;
    logic        id_q, last_q, rd_en_q, wr_en_q, done_q, err_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q, cpu_rd_q, vid_rd_q;
    logic [3:0]  mask_q;
    logic [15:0] cnt_q, cnt_d;
    logic        pick_valid, pick, hit;
    logic [31:0] rd_word;

    rr_pick2 u_pick (
        .cpu_req_i    (cpu_req),
        .vid_req_i    (vid_req),
        .vid_urgent_i (vid_urgent),
        .last_i       (last_q),
        .valid_o      (pick_valid),
        .pick_o       (pick)
    );

    assign cnt_d   = cnt_q + 16'd1;
    assign hit     = cnt_d == TMO;
    assign rd_word = ram_rd_valid ? ram_rd_data : ABORT_DATA;

    // Arbitration FSM: grant in IDLE, hold enables until response or timeout, one-cycle RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            id_q     <= PORT_CPU;
            last_q   <= PORT_VID;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            cpu_rd_q <= '0;
            vid_rd_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (pick_valid) begin
                    id_q    <= pick;
                    addr_q  <= pick ? vid_address : cpu_address;
                    wdata_q <= pick ? vid_wr_data : cpu_wr_data;
                    mask_q  <= pick ? vid_wr_mask : cpu_wr_mask;
                    wr_en_q <= pick ? vid_wr : cpu_wr;
                    rd_en_q <= pick ? !vid_wr : !cpu_wr;
                    cnt_q   <= '0;
                    state_q <= (pick ? vid_wr : cpu_wr) ? S_WRITE : S_READ;
                end
                S_READ: if (ram_rd_valid || hit) begin
                    rd_en_q <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= !ram_rd_valid;
                    state_q <= S_RESP;
                    if (id_q == PORT_VID) vid_rd_q <= rd_word;
                    else cpu_rd_q <= rd_word;
                end else begin
                    cnt_q <= cnt_d;
                end
                S_WRITE: if (ram_wr_ack || hit) begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= !ram_wr_ack;
                    state_q <= S_RESP;
                end else begin
                    cnt_q <= cnt_d;
                end
                S_RESP: begin
                    last_q  <= id_q;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_done      = done_q && id_q == PORT_CPU;
    assign vid_done      = done_q && id_q == PORT_VID;
    assign cpu_err       = err_q && id_q == PORT_CPU;
    assign vid_err       = err_q && id_q == PORT_VID;
    assign cpu_rd_data   = cpu_rd_q;
    assign vid_rd_data   = vid_rd_q;
    assign ram_address   = addr_q;
    assign ram_wr_data   = wdata_q;
    assign ram_wr_mask   = mask_q;
    assign ram_rd_enable = rd_en_q;
    assign ram_wr_enable = wr_en_q;
    assign arb_state     = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of grant order, timing, timeout and reset behaviour
module tb_ram_arbiter;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_req = 0, cpu_wr = 0, vid_req = 0, vid_wr = 0, vid_urgent = 0;
    logic [29:0] cpu_address = '0, vid_address = '0;
    logic [31:0] cpu_wr_data = '0, vid_wr_data = '0;
    logic [3:0]  cpu_wr_mask = '0, vid_wr_mask = '0;
    logic [31:0] cpu_rd_data, vid_rd_data, ram_wr_data;
    logic        cpu_done, cpu_err, vid_done, vid_err;
    logic [29:0] ram_address;
    logic        ram_wr_enable, ram_rd_enable;
    logic [3:0]  ram_wr_mask;
    logic        ram_wr_ack = 0, ram_rd_valid = 0;
    logic [31:0] ram_rd_data = '0;
    logic [1:0]  arb_state;

    int tests = 0, fails = 0;
    int rd_hi = 0, rd_rise = 0, wr_rise = 0, cpu_dn = 0, vid_dn = 0;
    int s_hi, s_rise, s_dn;
    logic rd_prev = 0, wr_prev = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_address(cpu_address),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_mask(cpu_wr_mask),
        .cpu_rd_data(cpu_rd_data), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .vid_req(vid_req), .vid_wr(vid_wr), .vid_address(vid_address),
        .vid_wr_data(vid_wr_data), .vid_wr_mask(vid_wr_mask),
        .vid_rd_data(vid_rd_data), .vid_done(vid_done), .vid_err(vid_err),
        .vid_urgent(vid_urgent),
        .ram_address(ram_address), .ram_wr_enable(ram_wr_enable), .ram_rd_enable(ram_rd_enable),
        .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask),
        .ram_wr_ack(ram_wr_ack), .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
        .arb_state(arb_state)
    );

    // Event counters sampled on the active edge (pre-update values)
    always @(posedge clk) begin
        if (ram_rd_enable) rd_hi <= rd_hi + 1;
        if (ram_rd_enable && !rd_prev) rd_rise <= rd_rise + 1;
        if (ram_wr_enable && !wr_prev) wr_rise <= wr_rise + 1;
        if (cpu_done) cpu_dn <= cpu_dn + 1;
        if (vid_done) vid_dn <= vid_dn + 1;
        rd_prev <= ram_rd_enable;
        wr_prev <= ram_wr_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        // reset state
        tick; tick;
        check("rst_state", 32'(arb_state), 0);
        check("rst_rd_en", 32'(ram_rd_enable), 0);
        check("rst_wr_en", 32'(ram_wr_enable), 0);
        check("rst_addr", 32'(ram_address), 0);
        check("rst_cpu_done", 32'(cpu_done), 0);
        check("rst_vid_rd", vid_rd_data, 0);
        rst_n = 1; tick;

        // CPU read, RAM answers on the third enabled cycle
        s_hi = rd_hi;
        cpu_req = 1; cpu_wr = 0; cpu_address = 30'h400;
        tick;
        check("t1_state_read", 32'(arb_state), 1);
        check("t1_rd_en", 32'(ram_rd_enable), 1);
        check("t1_addr", 32'(ram_address), 32'h400);
        tick; tick;
        ram_rd_valid = 1; ram_rd_data = 32'hDEADBEEF;
        tick;
        ram_rd_valid = 0;
        check("t1_done", 32'(cpu_done), 1);
        check("t1_err", 32'(cpu_err), 0);
        check("t1_data", cpu_rd_data, 32'hDEADBEEF);
        check("t1_state_resp", 32'(arb_state), 3);
        check("t1_rd_en_low", 32'(ram_rd_enable), 0);
        cpu_req = 0;
        tick;
        check("t1_done_pulse", 32'(cpu_done), 0);
        check("t1_idle", 32'(arb_state), 0);
        check("t1_en_cycles", 32'(rd_hi - s_hi), 3);

        // response arrives in the same cycle as the timeout: response wins
        cpu_req = 1; cpu_address = 30'h5;
        tick;
        repeat (7) tick;
        ram_rd_valid = 1; ram_rd_data = 32'hCAFEF00D;
        tick;
        ram_rd_valid = 0;
        check("race_done", 32'(cpu_done), 1);
        check("race_err", 32'(cpu_err), 0);
        check("race_data", cpu_rd_data, 32'hCAFEF00D);
        cpu_req = 0;
        tick;

        // VID read never answered: aborted after 8 cycles
        s_hi = rd_hi;
        vid_req = 1; vid_wr = 0; vid_address = 30'h2A;
        tick;
        repeat (7) tick;
        check("tmo_not_yet", 32'(vid_done), 0);
        check("tmo_en_still", 32'(ram_rd_enable), 1);
        tick;
        check("tmo_done", 32'(vid_done), 1);
        check("tmo_err", 32'(vid_err), 1);
        check("tmo_data", vid_rd_data, 32'hFFFFFFFF);
        check("tmo_en_low", 32'(ram_rd_enable), 0);
        vid_req = 0;
        tick;
        check("tmo_err_pulse", 32'(vid_err), 0);
        check("tmo_en_cycles", 32'(rd_hi - s_hi), 8);

        // tie after reset: CPU, then VID, then CPU again
        rst_n = 0; tick; rst_n = 1; tick;
        cpu_req = 1; cpu_wr = 1; cpu_address = 30'h1; cpu_wr_data = 32'h11111111; cpu_wr_mask = 4'h3;
        vid_req = 1; vid_wr = 1; vid_address = 30'h2; vid_wr_data = 32'h22222222; vid_wr_mask = 4'hC;
        tick;
        check("tie1_state", 32'(arb_state), 2);
        check("tie1_addr", 32'(ram_address), 1);
        check("tie1_wdata", ram_wr_data, 32'h11111111);
        check("tie1_mask", 32'(ram_wr_mask), 32'h3);
        ram_wr_ack = 1;
        tick;
        ram_wr_ack = 0;
        check("tie1_cpu_done", 32'(cpu_done), 1);
        check("tie1_vid_done", 32'(vid_done), 0);
        cpu_req = 0;
        tick; tick;
        check("tie2_addr", 32'(ram_address), 2);
        check("tie2_wdata", ram_wr_data, 32'h22222222);
        check("tie2_mask", 32'(ram_wr_mask), 32'hC);
        ram_wr_ack = 1;
        tick;
        ram_wr_ack = 0;
        check("tie2_vid_done", 32'(vid_done), 1);
        vid_req = 0;
        tick;
        cpu_req = 1; vid_req = 1;
        tick;
        check("tie3_addr", 32'(ram_address), 1);
        ram_wr_ack = 1;
        tick;
        ram_wr_ack = 0;
        check("tie3_cpu_done", 32'(cpu_done), 1);
        cpu_req = 0;
        tick; tick;
        ram_wr_ack = 1;
        tick;
        ram_wr_ack = 0;
        check("tie4_vid_done", 32'(vid_done), 1);
        vid_req = 0;
        tick;

        // urgent VID beats a CPU that would otherwise win the round robin
        cpu_req = 1; cpu_wr = 1;
        vid_req = 1; vid_wr = 0; vid_urgent = 1; vid_address = 30'h3;
        tick;
        check("urg_state", 32'(arb_state), 1);
        check("urg_addr", 32'(ram_address), 3);
        check("urg_wr_en", 32'(ram_wr_enable), 0);
        ram_rd_valid = 1; ram_rd_data = 32'h12345678;
        tick;
        ram_rd_valid = 0;
        check("urg_vid_done", 32'(vid_done), 1);
        check("urg_cpu_done", 32'(cpu_done), 0);
        check("urg_data", vid_rd_data, 32'h12345678);
        vid_req = 0; vid_urgent = 0;
        tick; tick;
        check("urg_cpu_next", 32'(arb_state), 2);
        check("urg_cpu_addr", 32'(ram_address), 1);
        ram_wr_ack = 1;
        tick;
        ram_wr_ack = 0;
        cpu_req = 0;
        tick;

        // reset in the middle of a write, stray ack afterwards
        s_dn = cpu_dn + vid_dn;
        cpu_req = 1; cpu_wr = 1; cpu_address = 30'h1;
        tick;
        check("mr_state_write", 32'(arb_state), 2);
        check("mr_wr_en", 32'(ram_wr_enable), 1);
        rst_n = 0; #1;
        check("mr_state", 32'(arb_state), 0);
        check("mr_wr_en_low", 32'(ram_wr_enable), 0);
        check("mr_addr", 32'(ram_address), 0);
        check("mr_wdata", ram_wr_data, 0);
        check("mr_vid_rd", vid_rd_data, 0);
        cpu_req = 0;
        tick;
        rst_n = 1; ram_wr_ack = 1;
        tick;
        ram_wr_ack = 0;
        tick; tick;
        check("mr_no_done", 32'(cpu_dn + vid_dn - s_dn), 0);
        check("mr_idle", 32'(arb_state), 0);
        check("mr_wr_en_idle", 32'(ram_wr_enable), 0);

        // requester holds req through the done cycle: single transaction
        s_rise = rd_rise; s_dn = cpu_dn;
        cpu_req = 1; cpu_wr = 0; cpu_address = 30'h7;
        tick;
        ram_rd_valid = 1; ram_rd_data = 32'hA5A5A5A5;
        tick;
        ram_rd_valid = 0;
        check("hold_done", 32'(cpu_done), 1);
        tick;
        cpu_req = 0;
        tick; tick; tick;
        check("hold_one_txn", 32'(rd_rise - s_rise), 1);
        check("hold_one_done", 32'(cpu_dn - s_dn), 1);
        check("hold_idle", 32'(arb_state), 0);
        check("hold_data", cpu_rd_data, 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
